// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches each active line one line ahead into a ping-pong buffer and streams it out with DE
module vga_line_fetch #(
    parameter int H_ACT_START = 200,
    parameter int H_PIX       = 640,
    parameter int V_ACT_START = 35,
    parameter int V_LINES     = 480,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [10:0]       HCNT,
    input  logic [9:0]        VCNT,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [DATA_W-1:0] PIX,
    output logic              DE,
    output logic              UNDERRUN
);
    localparam int CW = $clog2(H_PIX);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     col;
    logic [CW-1:0]     col_nxt;
    logic [CW-1:0]     rd;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] rb_new;
    logic              bank;
    logic              act_v;
    logic              act_h;
    logic              sol;
    logic              trig;
    logic              swap;
    logic              last;
    logic              we;
    logic              miss;
    logic [DATA_W-1:0] lbuf [2][H_PIX];

    assign act_v   = VCNT >= 10'(V_ACT_START) && VCNT <= 10'(V_ACT_START + V_LINES - 1);
    assign act_h   = HCNT >= 11'(H_ACT_START) && HCNT <= 11'(H_ACT_START + H_PIX - 1);
    assign sol     = HCNT == 11'd0;
    assign trig    = sol && VCNT >= 10'(V_ACT_START - 1) && VCNT <= 10'(V_ACT_START + V_LINES - 2);
    assign swap    = sol && act_v;
    assign rb_new  = (VCNT == 10'(V_ACT_START - 1)) ? '0 : row_base + ADDR_W'(H_PIX);
    assign col_nxt = col + CW'(1);
    assign last    = col == CW'(H_PIX - 1);
    assign rd      = CW'(HCNT - 11'(H_ACT_START));
    assign we      = state == FETCH && MEM_ACK && !trig;
    assign miss    = (trig && state == FETCH) || (swap && state != IDLE);

    // display reads BANK, fetch fills the other half; swap at the start of each active line
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) bank <= 1'b0;
        else if (swap) bank <= ~bank;

    // row base moves on every trigger, aborted fetches included, so rows never slip
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) row_base <= '0;
        else if (trig) row_base <= rb_new;

    // sticky deadline-miss flag
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) UNDERRUN <= 1'b0;
        else if (miss) UNDERRUN <= 1'b1;

    // request/acknowledge fetch engine; DRAIN absorbs the ack of an abandoned request
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state    <= IDLE;
            col      <= '0;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= '0;
        end else begin
            case (state)
                IDLE:
                    if (trig) begin
                        state    <= FETCH;
                        col      <= '0;
                        MEM_REQ  <= 1'b1;
                        MEM_ADDR <= rb_new;
                    end
                FETCH:
                    if (trig) begin
                        if (MEM_ACK) begin
                            col      <= '0;
                            MEM_ADDR <= rb_new;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (MEM_ACK) begin
                        if (last) begin
                            state   <= IDLE;
                            MEM_REQ <= 1'b0;
                        end else begin
                            col      <= col_nxt;
                            MEM_ADDR <= row_base + ADDR_W'(col_nxt);
                        end
                    end
                DRAIN:
                    if (MEM_ACK) begin
                        state    <= FETCH;
                        col      <= '0;
                        MEM_ADDR <= trig ? rb_new : row_base;
                    end
                default: state <= IDLE;
            endcase
        end

    // line-buffer write port, contents deliberately not reset
    always_ff @(posedge CLK)
        if (we) lbuf[~bank][col] <= MEM_DATA;

    // registered pixel and data enable, one clock behind HCNT
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            PIX <= '0;
            DE  <= 1'b0;
        end else begin
            DE  <= act_h && act_v;
            PIX <= (act_h && act_v) ? lbuf[bank][rd] : '0;
        end
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: scaled-down timing with a latency-programmable memory model and frame-level reference checks
module tb_vga_line_fetch;
    localparam int HS = 10, HP = 16, VS = 3, VL = 6, HT = 40, VT = 12, AW = 19, DW = 8;
    localparam logic [DW-1:0] MARK = 8'h33;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic [10:0]   HCNT = '0;
    logic [9:0]    VCNT = '0;
    logic          MEM_REQ;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_ACK = 1'b0;
    logic [DW-1:0] MEM_DATA = '0;
    logic [DW-1:0] PIX;
    logic          DE;
    logic          UNDERRUN;

    int cmp = 0, err = 0;
    int hc = HT - 1, vc = VT - 1, ph = 0, pv = 0;
    int mode = 0, lat = 0, lat_fix = 0, waited = 0;
    bit rnd = 1'b0;

    vga_line_fetch #(.H_ACT_START(HS), .H_PIX(HP), .V_ACT_START(VS), .V_LINES(VL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .HCNT(HCNT), .VCNT(VCNT),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
        .PIX(PIX), .DE(DE), .UNDERRUN(UNDERRUN)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [DW-1:0] f(input int a);
        return DW'(a) ^ 8'hA5;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        ph = hc;
        pv = vc;
        if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end else hc = hc + 1;
        HCNT = 11'(hc);
        VCNT = 10'(vc);
        MEM_ACK = 1'b0;
        if (!MEM_REQ) waited = 0;
        else if (mode == 1 ? hc == 0 : waited >= lat) begin
            MEM_ACK  = 1'b1;
            MEM_DATA = (mode == 1) ? MARK : f(int'(MEM_ADDR));
            waited   = 0;
            lat      = rnd ? int'($urandom_range(1, 0)) : lat_fix;
        end else waited++;
    endtask

    task automatic goto(input int v, input int h);
        int n = 0;
        while (!(vc == v && hc == h) && n <= HT * VT) begin
            step();
            n++;
        end
        cmp++;
        if (vc != v || hc != h) begin
            err++;
            $display("FAIL goto: reached line %0d col %0d, required line %0d col %0d", vc, hc, v, h);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        hc = HT - 1;
        vc = VT - 1;
        HCNT = 11'(hc);
        VCNT = 10'(vc);
        MEM_ACK = 1'b0;
        waited = 0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic run_frame(input bit exp_ur);
        int reqs = 0;
        goto(VT - 1, HT - 1);
        for (int i = 0; i < HT * VT; i++) begin
            bit de_e;
            logic [DW-1:0] px_e;
            step();
            de_e = pv >= VS && pv < VS + VL && ph >= HS && ph < HS + HP;
            px_e = de_e ? f((pv - VS) * HP + ph - HS) : '0;
            cmp++;
            if (DE !== de_e) begin
                err++;
                $display("FAIL frame_de: line %0d col %0d DE=%b required %b", pv, ph, DE, de_e);
            end
            cmp++;
            if (PIX !== px_e) begin
                err++;
                $display("FAIL frame_pix: line %0d col %0d PIX=%h required %h", pv, ph, PIX, px_e);
            end
            cmp++;
            if (UNDERRUN !== exp_ur) begin
                err++;
                $display("FAIL frame_underrun: line %0d col %0d UNDERRUN=%b required %b", vc, hc, UNDERRUN, exp_ur);
            end
            if (hc == 1 && vc >= VS - 1 && vc <= VS + VL - 2) begin
                cmp++;
                if (MEM_REQ !== 1'b1 || MEM_ADDR !== AW'((vc - VS + 1) * HP)) begin
                    err++;
                    $display("FAIL fetch_addr: line %0d REQ=%b ADDR=%0d required REQ=1 ADDR=%0d", vc, MEM_REQ, MEM_ADDR, (vc - VS + 1) * HP);
                end
            end
            if ((vc < VS - 1 || vc > VS + VL - 2) && MEM_REQ) reqs++;
        end
        cmp++;
        if (reqs != 0) begin
            err++;
            $display("FAIL idle_lines_req: %0d request cycles outside fetch lines, required 0", reqs);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        #1 RST_N = 1'b0;
        #1;
        cmp++;
        if ({MEM_REQ, DE, UNDERRUN} !== 3'b000 || MEM_ADDR !== '0 || PIX !== '0) begin
            err++;
            $display("FAIL reset_outputs: REQ=%b DE=%b UR=%b ADDR=%0d PIX=%h required all 0", MEM_REQ, DE, UNDERRUN, MEM_ADDR, PIX);
        end
        do_reset();
        for (int i = 0; i < 2 * HT; i++) begin
            step();
            if (MEM_REQ !== 1'b0 || DE !== 1'b0 || UNDERRUN !== 1'b0) bad++;
        end
        cmp++;
        if (bad != 0) begin
            err++;
            $display("FAIL reset_quiet: %0d active cycles in lines 0..1 after reset, required 0", bad);
        end
    endtask

    task automatic test_fast_frames();
        mode = 0; rnd = 1'b0; lat_fix = 0; lat = 0;
        do_reset();
        run_frame(1'b0);
        run_frame(1'b0);
    endtask

    task automatic test_random_latency();
        rnd = 1'b1;
        lat = int'($urandom_range(1, 0));
        run_frame(1'b0);
        rnd = 1'b0;
    endtask

    task automatic test_slow_underrun();
        logic [AW-1:0] a0;
        int n = 0;
        mode = 0; rnd = 1'b0; lat_fix = 2; lat = 2;
        do_reset();
        goto(VS, 0);
        cmp++;
        if (UNDERRUN !== 1'b0) begin
            err++;
            $display("FAIL slow_before_deadline: UNDERRUN=%b required 0", UNDERRUN);
        end
        step();
        cmp++;
        if (UNDERRUN !== 1'b1) begin
            err++;
            $display("FAIL slow_deadline: UNDERRUN=%b required 1", UNDERRUN);
        end
        a0 = MEM_ADDR;
        while (MEM_ADDR === a0 && n < HT) begin
            step();
            n++;
        end
        cmp++;
        if (MEM_ADDR !== AW'(HP)) begin
            err++;
            $display("FAIL slow_after_drain: ADDR=%0d required %0d", MEM_ADDR, HP);
        end
        goto(VT - 1, HT - 1);
        cmp++;
        if (UNDERRUN !== 1'b1) begin
            err++;
            $display("FAIL slow_sticky: UNDERRUN=%b required 1", UNDERRUN);
        end
        lat_fix = 0; lat = 0;
        run_frame(1'b1);
    endtask

    task automatic test_ack_on_trig();
        mode = 1; rnd = 1'b0; lat_fix = 0; lat = 0;
        do_reset();
        goto(VS, 1);
        cmp++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== AW'(HP)) begin
            err++;
            $display("FAIL trig_ack_restart: REQ=%b ADDR=%0d required REQ=1 ADDR=%0d", MEM_REQ, MEM_ADDR, HP);
        end
        cmp++;
        if (UNDERRUN !== 1'b1) begin
            err++;
            $display("FAIL trig_ack_underrun: UNDERRUN=%b required 1", UNDERRUN);
        end
        mode = 0;
        goto(VS, HS + 1);
        cmp++;
        if (DE !== 1'b1 || PIX === MARK) begin
            err++;
            $display("FAIL trig_ack_discard: DE=%b PIX=%h required DE=1 and PIX other than %h", DE, PIX, MARK);
        end
        goto(VS + 1, HS + 1);
        for (int x = 0; x < HP; x++) begin
            cmp++;
            if (PIX !== f(HP + x)) begin
                err++;
                $display("FAIL trig_ack_refetch: pixel %0d PIX=%h required %h", x, PIX, f(HP + x));
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        int reqs = 0;
        int n = 0;
        mode = 0; rnd = 1'b0; lat_fix = 2; lat = 2;
        do_reset();
        goto(VS + 2, HS + 5);
        cmp++;
        if (MEM_REQ !== 1'b1 || DE !== 1'b1 || UNDERRUN !== 1'b1) begin
            err++;
            $display("FAIL areset_pre: REQ=%b DE=%b UR=%b required 1 1 1", MEM_REQ, DE, UNDERRUN);
        end
        RST_N = 1'b0;
        #1;
        cmp++;
        if ({MEM_REQ, DE, UNDERRUN} !== 3'b000 || PIX !== '0 || MEM_ADDR !== '0) begin
            err++;
            $display("FAIL areset_immediate: REQ=%b DE=%b UR=%b PIX=%h ADDR=%0d required all 0", MEM_REQ, DE, UNDERRUN, PIX, MEM_ADDR);
        end
        goto(VS + VL, 0);
        RST_N = 1'b1;
        lat_fix = 0; lat = 0;
        while (!(vc == VS - 1 && hc == 0) && n <= HT * VT) begin
            step();
            if (MEM_REQ) reqs++;
            n++;
        end
        cmp++;
        if (reqs != 0 || vc != VS - 1 || hc != 0) begin
            err++;
            $display("FAIL areset_quiet: %0d request cycles, stopped at line %0d col %0d, required 0 at line %0d col 0", reqs, vc, hc, VS - 1);
        end
        step();
        cmp++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== '0) begin
            err++;
            $display("FAIL areset_first_req: REQ=%b ADDR=%0d required REQ=1 ADDR=0", MEM_REQ, MEM_ADDR);
        end
    endtask

    initial begin
        test_reset();
        test_fast_frames();
        test_random_latency();
        test_slow_underrun();
        test_ack_on_trig();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
